// File: rtl/video_frame_checker_pkg.sv
// Shared types and the 24-bit-per-step CRC-32 helper for the video frame checker.
package video_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2
    } checker_state_t;

    // MSB-first, non-reflected fold of one pixel, bit 23 entering first.
    function automatic logic [31:0] crc32_step24(input logic [31:0] crc, input logic [23:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = (c << 1) ^ CRC32_POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/video_frame_checker_if.sv
// Display video bus: pixel data, active qualifier and the two one-cycle sync pulses.
interface video_frame_checker_if;
    logic [23:0] video_rgb;
    logic        video_enable;
    logic        vsync_start;
    logic        hsync_start;

    modport master (output video_rgb, output video_enable, output vsync_start, output hsync_start);
    modport slave  (input  video_rgb, input  video_enable, input  vsync_start, input  hsync_start);
endinterface

// File: rtl/video_crc32_acc.sv
// Registered CRC-32 accumulator: one 24-bit pixel per enabled cycle, clear reseeds.
module video_crc32_acc
    import video_pkg::*;
#(
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [23:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] seed;

    // A pixel arriving with clear belongs to the new run, so it folds onto the seed.
    always_comb begin
        seed  = clear_i ? CRC_INIT : crc_q;
        crc_d = en_i ? crc32_step24(seed, data_i) : seed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/video_frame_checker.sv
// Sink-side video checker: rebuilds coordinates, measures frame geometry, CRCs active pixels.
module video_frame_checker
    import video_pkg::*;
#(
    parameter int          COORD_WIDTH = 16,
    parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF
) (
    input  logic                   pixel_clock,
    input  logic                   reset_n,
    video_frame_checker_if.slave   vid,
    output logic [COORD_WIDTH-1:0] rx_x,
    output logic [COORD_WIDTH-1:0] rx_y,
    output logic [COORD_WIDTH-1:0] active_width,
    output logic [COORD_WIDTH-1:0] active_height,
    output logic [31:0]            frame_crc,
    output logic                   frame_done,
    output logic                   locked,
    output logic                   geom_err
);

    typedef logic [COORD_WIDTH-1:0] coord_t;
    localparam coord_t COORD_MAX = '1;

    checker_state_t state_q, state_d;
    coord_t pix_cnt_q, pix_cnt_d;
    coord_t line_cnt_q, line_cnt_d;
    coord_t ref_w_q, ref_w_d;
    coord_t rx_x_q, rx_x_d;
    coord_t rx_y_q, rx_y_d;
    coord_t act_w_q, act_w_d;
    coord_t act_h_q, act_h_d;
    logic [31:0] frame_crc_q, frame_crc_d;
    logic frame_done_q, frame_done_d;
    logic geom_err_q, geom_err_d;
    logic have_prev_q, have_prev_d;

    logic [31:0] crc_run;
    logic        close_line;
    coord_t      line_cnt_closed;
    coord_t      ref_w_closed;
    coord_t      pix_base;
    logic        geom_now;
    logic        lock_ok;

    video_crc32_acc #(.CRC_INIT(CRC_INIT)) u_crc (
        .clk     (pixel_clock),
        .rst_n   (reset_n),
        .clear_i (vid.vsync_start),
        .en_i    (vid.video_enable),
        .data_i  (vid.video_rgb),
        .crc_o   (crc_run)
    );

    always_comb begin
        // A vsync closes the open line exactly like an hsync, even when both arrive together.
        close_line      = (vid.hsync_start || vid.vsync_start) && (pix_cnt_q != '0);
        line_cnt_closed = line_cnt_q;
        ref_w_closed    = ref_w_q;
        geom_now        = geom_err_q || (pix_cnt_q == COORD_MAX) || (line_cnt_q == COORD_MAX);
        if (close_line) begin
            if (line_cnt_q != COORD_MAX) begin
                line_cnt_closed = line_cnt_q + COORD_WIDTH'(1);
            end
            if (line_cnt_q == '0) begin
                ref_w_closed = pix_cnt_q;
            end else if (pix_cnt_q != ref_w_q) begin
                geom_now = 1'b1;
            end
        end
        pix_base = (vid.hsync_start || vid.vsync_start) ? '0 : pix_cnt_q;
        lock_ok  = have_prev_q && (ref_w_closed == act_w_q) && (line_cnt_closed == act_h_q) && !geom_now;

        state_d      = state_q;
        pix_cnt_d    = pix_base;
        line_cnt_d   = line_cnt_closed;
        ref_w_d      = ref_w_closed;
        geom_err_d   = geom_now;
        rx_x_d       = rx_x_q;
        rx_y_d       = rx_y_q;
        act_w_d      = act_w_q;
        act_h_d      = act_h_q;
        frame_crc_d  = frame_crc_q;
        frame_done_d = 1'b0;
        have_prev_d  = have_prev_q;

        if (vid.video_enable) begin
            pix_cnt_d = (pix_base == COORD_MAX) ? COORD_MAX : pix_base + COORD_WIDTH'(1);
            rx_x_d    = pix_base;
            if (pix_base == '0) begin
                rx_y_d = vid.vsync_start ? '0 : line_cnt_closed;
            end
        end

        if (vid.vsync_start) begin
            line_cnt_d = '0;
            ref_w_d    = '0;
            geom_err_d = 1'b0;
            if (state_q == UNLOCKED) begin
                state_d = MEASURE;
            end else begin
                act_w_d      = ref_w_closed;
                act_h_d      = line_cnt_closed;
                frame_crc_d  = crc_run;
                frame_done_d = 1'b1;
                have_prev_d  = 1'b1;
                state_d      = lock_ok ? LOCKED : MEASURE;
            end
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= UNLOCKED;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            ref_w_q      <= '0;
            geom_err_q   <= 1'b0;
            rx_x_q       <= '0;
            rx_y_q       <= '0;
            act_w_q      <= '0;
            act_h_q      <= '0;
            frame_crc_q  <= '0;
            frame_done_q <= 1'b0;
            have_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            ref_w_q      <= ref_w_d;
            geom_err_q   <= geom_err_d;
            rx_x_q       <= rx_x_d;
            rx_y_q       <= rx_y_d;
            act_w_q      <= act_w_d;
            act_h_q      <= act_h_d;
            frame_crc_q  <= frame_crc_d;
            frame_done_q <= frame_done_d;
            have_prev_q  <= have_prev_d;
        end
    end

    assign rx_x          = rx_x_q;
    assign rx_y          = rx_y_q;
    assign active_width  = act_w_q;
    assign active_height = act_h_q;
    assign frame_crc     = frame_crc_q;
    assign frame_done    = frame_done_q;
    assign locked        = (state_q == LOCKED);
    assign geom_err      = geom_err_q;

endmodule

// File: tb/tb_video_frame_checker.sv
// Directed-stimulus bench with a frame-level reference model and a per-cycle output compare.
module tb_video_frame_checker;

    logic        pixel_clock = 1'b0;
    logic        reset_n     = 1'b0;
    logic [15:0] rx_x, rx_y, active_width, active_height;
    logic [31:0] frame_crc;
    logic        frame_done, locked, geom_err;

    video_frame_checker_if vif();

    video_frame_checker #(.COORD_WIDTH(16), .CRC_INIT(32'hFFFF_FFFF)) dut (
        .pixel_clock   (pixel_clock),
        .reset_n       (reset_n),
        .vid           (vif),
        .rx_x          (rx_x),
        .rx_y          (rx_y),
        .active_width  (active_width),
        .active_height (active_height),
        .frame_crc     (frame_crc),
        .frame_done    (frame_done),
        .locked        (locked),
        .geom_err      (geom_err)
    );

    always #5 pixel_clock = ~pixel_clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct { int due; int w; int h; logic [31:0] crc; bit lk; } frame_exp_t;
    typedef struct { int due; int x; int y; } px_exp_t;
    typedef struct { int due; bit v; } bit_exp_t;
    frame_exp_t fq[$];
    px_exp_t    pq[$];
    bit_exp_t   gq[$];

    int          exp_w, exp_h;
    logic [31:0] exp_crc;
    bit          exp_lk;
    bit          fd_exp;

    // Reference model: frame-level bookkeeping of closed line widths and pixel CRC.
    bit          m_synced, m_have_prev;
    int          m_pw, m_ph, m_line_px;
    int          m_widths[$];
    logic [31:0] m_crc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-wise CRC-32/MPEG-2 style update over the three bytes of a pixel.
    function automatic logic [31:0] crc_px(input logic [31:0] c_in, input logic [23:0] rgb);
        logic [31:0] c;
        logic [7:0]  b;
        c = c_in;
        for (int k = 2; k >= 0; k--) begin
            b = rgb[k*8 +: 8];
            c = c ^ {b, 24'h0};
            for (int j = 0; j < 8; j++) begin
                c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic bit m_geom_bad();
        foreach (m_widths[i]) begin
            if (m_widths[i] != m_widths[0]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        logic [23:0] ascii [3];
        ascii[0] = 24'h313233;
        ascii[1] = 24'h343536;
        ascii[2] = 24'h373839;
        case (mode)
            1:       return 24'h0;
            2:       return (x >= 0 && x < 3) ? ascii[x] : 24'hABCDEF;
            default: return {8'(x * 7 + y), 8'(y * 3), 8'(x ^ y)};
        endcase
    endfunction

    task automatic model_reset();
        fq.delete(); pq.delete(); gq.delete();
        exp_w = 0; exp_h = 0; exp_crc = 32'h0; exp_lk = 1'b0;
        m_synced = 1'b0; m_have_prev = 1'b0; m_pw = 0; m_ph = 0; m_line_px = 0;
        m_widths.delete();
        m_crc = 32'hFFFF_FFFF;
    endtask

    task automatic model_frame_close();
        int w, h;
        bit err, lk;
        w   = (m_widths.size() > 0) ? m_widths[0] : 0;
        h   = m_widths.size();
        err = m_geom_bad();
        if (m_synced) begin
            lk = m_have_prev && (w == m_pw) && (h == m_ph) && !err;
            fq.push_back('{cyc + 1, w, h, m_crc, lk});
            m_have_prev = 1'b1;
            m_pw = w;
            m_ph = h;
        end
        m_synced = 1'b1;
        m_widths.delete();
        m_crc = 32'hFFFF_FFFF;
    endtask

    task automatic drive(input bit vs, input bit hs, input bit en, input logic [23:0] rgb);
        @(posedge pixel_clock);
        #1;
        vif.vsync_start  = vs;
        vif.hsync_start  = hs;
        vif.video_enable = en;
        vif.video_rgb    = rgb;
        if ((vs || hs) && m_line_px != 0) m_widths.push_back(m_line_px);
        if (vs || hs) m_line_px = 0;
        if (vs) model_frame_close();
        if (en) begin
            pq.push_back('{cyc + 1, m_line_px, m_widths.size()});
            m_line_px++;
            m_crc = crc_px(m_crc, rgb);
        end
        gq.push_back('{cyc + 1, m_geom_bad()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'h5A5A5A);
    endtask

    task automatic vsync();
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        idle(3);
    endtask

    task automatic send_frame(input int w, input int h, input int htot, input int vtot,
                              input int short_line, input int short_w, input int mode);
        int lw;
        bit en;
        for (int y = 0; y < vtot; y++) begin
            lw = (y == short_line) ? short_w : w;
            for (int c = 0; c < htot; c++) begin
                en = (y < h) && (c >= 1) && (c <= lw);
                drive(1'b0, c == 0, en, pix(mode, c - 1, y));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_x"}, rx_x, 0);
        check({tag, "_rx_y"}, rx_y, 0);
        check({tag, "_width"}, active_width, 0);
        check({tag, "_height"}, active_height, 0);
        check({tag, "_crc"}, frame_crc, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_geom_err"}, geom_err, 0);
    endtask

    task automatic apply_reset();
        @(posedge pixel_clock);
        #3;
        reset_n = 1'b0;
        vif.vsync_start = 1'b0; vif.hsync_start = 1'b0; vif.video_enable = 1'b0; vif.video_rgb = 24'h0;
        model_reset();
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge pixel_clock);
        #3;
        reset_n = 1'b1;
    endtask

    always @(posedge pixel_clock) cyc <= cyc + 1;

    always @(negedge pixel_clock) begin
        if (reset_n) begin
            fd_exp = (fq.size() > 0) && (fq[0].due == cyc);
            check("frame_done", frame_done, fd_exp);
            if (frame_done) done_cnt++;
            if (fd_exp) begin
                exp_w = fq[0].w; exp_h = fq[0].h; exp_crc = fq[0].crc; exp_lk = fq[0].lk;
                void'(fq.pop_front());
            end
            check("active_width", active_width, exp_w);
            check("active_height", active_height, exp_h);
            check("frame_crc", frame_crc, exp_crc);
            check("locked", locked, exp_lk);
            if (pq.size() > 0 && pq[0].due == cyc) begin
                check("rx_x", rx_x, pq[0].x);
                check("rx_y", rx_y, pq[0].y);
                void'(pq.pop_front());
            end
            if (gq.size() > 0 && gq[0].due == cyc) begin
                check("geom_err", geom_err, gq[0].v);
                void'(gq.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vif.vsync_start = 1'b0; vif.hsync_start = 1'b0; vif.video_enable = 1'b0; vif.video_rgb = 24'h0;
        model_reset();
        repeat (3) @(posedge pixel_clock);
        #1;
        check_all_zero("reset");
        @(posedge pixel_clock);
        #3;
        reset_n = 1'b1;

        // Two full frames after the sync vsync: two frame_done pulses, then locked.
        d0 = done_cnt;
        vsync();
        send_frame(40, 36, 48, 40, -1, 0, 0);
        vsync();
        send_frame(40, 36, 48, 40, -1, 0, 0);
        vsync();
        check("lock_done_count", done_cnt - d0, 2);
        check("lock_width", active_width, 40);
        check("lock_height", active_height, 36);
        check("lock_locked", locked, 1);

        // Line 10 one pixel short: sticky error until the frame closes, lock drops.
        send_frame(40, 36, 48, 40, 10, 39, 0);
        check("short_geom_err_held", geom_err, 1);
        vsync();
        check("short_geom_err_cleared", geom_err, 0);
        check("short_locked", locked, 0);
        check("short_width", active_width, 40);

        send_frame(40, 36, 48, 40, -1, 0, 0);
        vsync();
        check("relock_locked", locked, 1);

        // Geometry change: first new frame unlocked, second relocks.
        send_frame(32, 24, 40, 26, -1, 0, 0);
        vsync();
        check("geo_width", active_width, 32);
        check("geo_height", active_height, 24);
        check("geo_locked", locked, 0);
        send_frame(32, 24, 40, 26, -1, 0, 0);
        vsync();
        check("geo_relocked", locked, 1);

        // Reset mid-frame: the first vsync after release only synchronises.
        send_frame(32, 24, 40, 10, -1, 0, 0);
        apply_reset();
        d0 = done_cnt;
        vsync();
        check("post_rst_no_done", done_cnt - d0, 0);
        send_frame(32, 24, 40, 26, -1, 0, 0);
        vsync();
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_height", active_height, 24);
        check("post_rst_locked", locked, 0);

        // 1x1 all-zero frames give the single-pixel golden CRC every time.
        send_frame(1, 1, 4, 2, -1, 0, 1);
        vsync();
        check("zero_crc_1", frame_crc, crc_px(32'hFFFF_FFFF, 24'h0));
        send_frame(1, 1, 4, 2, -1, 0, 1);
        vsync();
        check("zero_crc_2", frame_crc, crc_px(32'hFFFF_FFFF, 24'h0));
        check("zero_locked", locked, 1);

        // "123456789" as three pixels: the published CRC-32/MPEG-2 check value.
        send_frame(3, 1, 5, 2, -1, 0, 2);
        vsync();
        check("ascii_crc", frame_crc, 32'h0376_E6E7);
        check("ascii_width", active_width, 3);

        // 4x3 frame, pixels on the hsync cycle, ended by a combined vsync+hsync.
        for (int y = 0; y < 3; y++) begin
            for (int c = 0; c < 4; c++) begin
                drive(1'b0, c == 0, 1'b1, pix(0, c, y));
                if (y == 1 && c == 1) begin
                    check("hs_pixel_rx_x", rx_x, 0);
                    check("hs_pixel_rx_y", rx_y, 1);
                end
            end
        end
        vsync();
        check("combo_height", active_height, 3);
        check("combo_width", active_width, 4);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
